addsub_opseq: RTL and testbench

//  Upstream operand sequencer for the 2-bit add/subtract datapath (addsub).

---
 rtl/addsub_opseq_if.sv | 31 +++
 rtl/addsub_opseq.sv | 103 ++++++++++
 tb/tb_addsub_opseq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/addsub_opseq_if.sv
// Operand/result bundle between the switch-driven sequencer and the addsub datapath.
// master = the sequencer, slave = the board/datapath side.
interface addsub_opseq_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 4
);
    logic [WIDTH-1:0] sw;
    logic             mode_sw;
    logic             btn_load;
    logic             op_ready;
    logic [WIDTH-1:0] sum_in;
    logic             cbout_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             op_valid;
    logic [WIDTH-1:0] res;
    logic             res_cbout;
    logic [CNT_W-1:0] op_cnt;
    logic [1:0]       state;

    modport master (
        input  sw, mode_sw, btn_load, op_ready, sum_in, cbout_in,
        output a, b, mode, op_valid, res, res_cbout, op_cnt, state
    );

    modport slave (
        output sw, mode_sw, btn_load, op_ready, sum_in, cbout_in,
        input  a, b, mode, op_valid, res, res_cbout, op_cnt, state
    );
endinterface

// File: rtl/addsub_opseq.sv
// Operand sequencer for addsub: loads A, then B/mode on button presses, issues
// them under valid/ready and latches the result. Optional OPSEQ_AUTOSTEP_EN
// keeps re-issuing with b incremented after every handshake.
module addsub_opseq #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    addsub_opseq_if.master    bus
);
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        ISSUE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic             btn_q_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             mode_reg;
    logic             op_valid_reg;
    logic [WIDTH-1:0] res_reg;
    logic             res_cbout_reg;
    logic [CNT_W-1:0] op_cnt_reg;

    logic ld;
    logic handshake;

    assign ld        = bus.btn_load & ~btn_q_reg;
    assign handshake = op_valid_reg & bus.op_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= LOAD_A;
            // Starts "pressed" so a button held through reset release is not a load.
            btn_q_reg     <= 1'b1;
            a_reg         <= '0;
            b_reg         <= '0;
            mode_reg      <= 1'b0;
            op_valid_reg  <= 1'b0;
            res_reg       <= '0;
            res_cbout_reg <= 1'b0;
            op_cnt_reg    <= '0;
        end else begin
            btn_q_reg <= bus.btn_load;
            case (state_reg)
                LOAD_A: begin
                    if (ld) begin
                        a_reg     <= bus.sw;
                        state_reg <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (ld) begin
                        b_reg        <= bus.sw;
                        mode_reg     <= bus.mode_sw;
                        op_valid_reg <= 1'b1;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (handshake) begin
                        res_reg       <= bus.sum_in;
                        res_cbout_reg <= bus.cbout_in;
                        op_cnt_reg    <= op_cnt_reg + CNT_W'(1);
                    end
`ifdef OPSEQ_AUTOSTEP_EN
                    // A press abandons the stepping run, even on a handshake cycle.
                    if (ld) begin
                        op_valid_reg <= 1'b0;
                        state_reg    <= LOAD_A;
                    end else if (handshake) begin
                        op_valid_reg <= 1'b0;
                        b_reg        <= b_reg + WIDTH'(1);
                    end else begin
                        op_valid_reg <= 1'b1;
                    end
`else
                    if (handshake) begin
                        op_valid_reg <= 1'b0;
                        state_reg    <= LOAD_A;
                    end
`endif
                end
                default: begin
                    op_valid_reg <= 1'b0;
                    state_reg    <= LOAD_A;
                end
            endcase
        end
    end

    assign bus.a         = a_reg;
    assign bus.b         = b_reg;
    assign bus.mode      = mode_reg;
    assign bus.op_valid  = op_valid_reg;
    assign bus.res       = res_reg;
    assign bus.res_cbout = res_cbout_reg;
    assign bus.op_cnt    = op_cnt_reg;
    assign bus.state     = state_reg;
endmodule

// File: tb/tb_addsub_opseq.sv
// Directed bench for addsub_opseq with a scoreboard of expected results that is
// drained by a handshake monitor; a small addsub stub feeds sum_in/cbout_in.
module tb_addsub_opseq;
    localparam int WIDTH = 2;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    addsub_opseq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    addsub_opseq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [WIDTH:0]   exp_q[$];
    logic [CNT_W-1:0] cnt_model = '0;

    // Downstream addsub stand-in: {carry/borrow, sum}.
    always_comb begin
        if (bus.mode) {bus.cbout_in, bus.sum_in} = {1'b0, bus.a} - {1'b0, bus.b};
        else          {bus.cbout_in, bus.sum_in} = {1'b0, bus.a} + {1'b0, bus.b};
    end

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic m);
        return m ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_edge(input logic [WIDTH-1:0] s, input logic m);
        bus.sw       = s;
        bus.mode_sw  = m;
        bus.btn_load = 1'b1;
        step();
    endtask

    task automatic release_btn();
        bus.btn_load = 1'b0;
        step();
    endtask

    // Full operation with op_ready already high: handshake lands on the last release.
    task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic m);
        press_edge(x, 1'b0);
        release_btn();
        exp_q.push_back(model(x, y, m));
        press_edge(y, m);
        release_btn();
        check("op_done_state", bus.state, 0);
    endtask

    // Handshake monitor: pops the scoreboard and checks the latched result.
    always @(posedge clk) begin
        if (rst_n && bus.op_valid && bus.op_ready) begin
            logic [WIDTH:0] e;
            #1;
            cnt_model = cnt_model + CNT_W'(1);
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("txn: a=%0d b=%0d mode=%0d res=%0d cb=%0d cnt=%0d",
                         bus.a, bus.b, bus.mode, bus.res, bus.res_cbout, bus.op_cnt);
                check("res", bus.res, e[WIDTH-1:0]);
                check("res_cbout", bus.res_cbout, e[WIDTH]);
            end
            check("op_cnt", bus.op_cnt, cnt_model);
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.btn_load = 1'b1;
        bus.sw       = '0;
        bus.mode_sw  = 1'b0;
        bus.op_ready = 1'b0;

        // Reset with the button held, then release reset still holding it.
        step();
        step();
        check("rst_a", bus.a, 0);
        check("rst_b", bus.b, 0);
        check("rst_mode", bus.mode, 0);
        check("rst_valid", bus.op_valid, 0);
        check("rst_res", {bus.res_cbout, bus.res}, 0);
        check("rst_cnt", bus.op_cnt, 0);
        check("rst_state", bus.state, 0);
        rst_n  = 1'b1;
        bus.sw = 2'b11;
        for (int i = 0; i < 5; i++) step();
        check("held_no_load_state", bus.state, 0);
        check("held_no_load_a", bus.a, 0);
        release_btn();

`ifdef OPSEQ_AUTOSTEP_EN
        // Auto-stepping from a=0, b=3 with op_ready high.
        bus.op_ready = 1'b1;
        press_edge(2'b00, 1'b0);
        release_btn();
        for (int i = 0; i < 4; i++) exp_q.push_back(model(2'd0, WIDTH'(3 + i), 1'b0));
        press_edge(2'b11, 1'b0);
        check("as_valid0", bus.op_valid, 1);
        check("as_b0", bus.b, 3);
        bus.btn_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("as_gap_valid", bus.op_valid, 0);
            check("as_gap_b", bus.b, WIDTH'(4 + i));
            step();
            check("as_issue_valid", bus.op_valid, 1);
            check("as_issue_b", bus.b, WIDTH'(4 + i));
        end
        // Press coincides with the fourth handshake.
        bus.btn_load = 1'b1;
        step();
        check("as_exit_state", bus.state, 0);
        check("as_exit_valid", bus.op_valid, 0);
        release_btn();
`else
        // Add with op_ready already high: op_valid lasts one cycle.
        bus.op_ready = 1'b1;
        press_edge(2'b10, 1'b0);
        check("t2_a", bus.a, 2);
        check("t2_state_b", bus.state, 1);
        release_btn();
        exp_q.push_back(model(2'd2, 2'd1, 1'b0));
        press_edge(2'b01, 1'b0);
        check("t2_b", bus.b, 1);
        check("t2_mode", bus.mode, 0);
        check("t2_valid_hi", bus.op_valid, 1);
        check("t2_state_issue", bus.state, 2);
        release_btn();
        check("t2_valid_lo", bus.op_valid, 0);
        check("t2_state_done", bus.state, 0);
        check("t2_res_const", bus.res, 3);

        // Stalled issue: presses and switch changes are ignored.
        bus.op_ready = 1'b0;
        press_edge(2'b10, 1'b0);
        release_btn();
        exp_q.push_back(model(2'd2, 2'd1, 1'b1));
        press_edge(2'b01, 1'b1);
        release_btn();
        for (int i = 0; i < 5; i++) begin
            bus.btn_load = ~bus.btn_load;
            bus.sw       = WIDTH'($urandom_range(0, 3));
            bus.mode_sw  = ~bus.mode_sw;
            step();
            check("t3_valid", bus.op_valid, 1);
            check("t3_abm", {bus.a, bus.b, bus.mode}, {2'd2, 2'd1, 1'b1});
            check("t3_state", bus.state, 2);
        end
        bus.btn_load = 1'b0;
        bus.op_ready = 1'b1;
        step();
        check("t3_state_done", bus.state, 0);

        // Long hold in LOAD_A produces exactly one load.
        bus.sw       = 2'b11;
        bus.btn_load = 1'b1;
        step();
        bus.sw = 2'b00;
        for (int i = 0; i < 9; i++) step();
        check("t4_a", bus.a, 3);
        check("t4_b_kept", bus.b, 1);
        check("t4_state", bus.state, 1);
        release_btn();

        // Finish this op (3+1 carries), then run up to the counter wrap.
        exp_q.push_back(model(2'd3, 2'd1, 1'b0));
        press_edge(2'b01, 1'b0);
        release_btn();
        for (int i = 0; i < 13; i++)
            do_op(WIDTH'($urandom_range(0, 3)), WIDTH'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        check("t5_cnt_wrap", bus.op_cnt, 0);
        do_op(2'd0, 2'd1, 1'b1);
        check("t5_sub_res", bus.res, 3);
        check("t5_sub_cb", bus.res_cbout, 1);
        check("t5_cnt_after", bus.op_cnt, 1);
`endif

        step();
        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
